// File: rtl/modem_mode_sched.sv
// Mode-switch scheduler: synchronises and debounces the mode select, then switches the
// datapath mode on a symbol boundary behind a mute/flush/clear/settle sequence.
module modem_mode_sched #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int SYM_TIMEOUT  = 1024,
    parameter int FLUSH_CYC    = 8,
    parameter int SETTLE_CYC   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [1:0] sel_in,
    input  logic       sym_tick,
    output logic [1:0] mode,
    output logic       dp_clr,
    output logic       mute,
    output logic       demod_en,
    output logic       busy,
    output logic       mode_done
);

    localparam int CNT_MAX_A = (SYM_TIMEOUT > SETTLE_CYC) ? SYM_TIMEOUT : SETTLE_CYC;
    localparam int CNT_MAX   = (CNT_MAX_A > FLUSH_CYC) ? CNT_MAX_A : FLUSH_CYC;
    localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int DB_W      = $clog2(DEBOUNCE_CYC + 1);

    typedef enum logic [1:0] {ST_RUN, ST_WAIT_SYM, ST_FLUSH, ST_SETTLE} state_t;

    // Two-flop synchroniser per select bit
    logic [1:0] s;
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= sel_in[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign s[gi] = sync_reg;
        end
    endgenerate

    logic [1:0]      s_prev_reg;
    logic [1:0]      req_reg;
    logic [DB_W-1:0] db_cnt_reg;
    logic [DB_W-1:0] db_run;

    // A fresh value of s counts as the first stable cycle of its own run
    always_comb begin
        db_run = (s != s_prev_reg) ? DB_W'(1) : db_cnt_reg + DB_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_prev_reg <= 2'd0;
            req_reg    <= 2'd0;
            db_cnt_reg <= '0;
        end else begin
            s_prev_reg <= s;
            if (s == req_reg) begin
                db_cnt_reg <= '0;
            end else if (db_run == DB_W'(DEBOUNCE_CYC)) begin
                req_reg    <= s;
                db_cnt_reg <= '0;
            end else begin
                db_cnt_reg <= db_run;
            end
        end
    end

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       mode_reg, mode_next;
    logic             sw_reg, sw_next;
    logic             dp_clr_reg, dp_clr_next;
    logic             mute_reg, mute_next;
    logic             demod_en_reg, demod_en_next;
    logic             busy_reg, busy_next;
    logic             mode_done_reg, mode_done_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_SETTLE;
            cnt_reg       <= '0;
            mode_reg      <= 2'd0;
            sw_reg        <= 1'b0;
            dp_clr_reg    <= 1'b0;
            mute_reg      <= 1'b1;
            demod_en_reg  <= 1'b0;
            busy_reg      <= 1'b1;
            mode_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            mode_reg      <= mode_next;
            sw_reg        <= sw_next;
            dp_clr_reg    <= dp_clr_next;
            mute_reg      <= mute_next;
            demod_en_reg  <= demod_en_next;
            busy_reg      <= busy_next;
            mode_done_reg <= mode_done_next;
        end
    end

    // sw_reg marks a SETTLE entered from FLUSH, so the reset-entry SETTLE gives no mode_done
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        mode_next  = mode_reg;
        sw_next    = sw_reg;
        if (!ena) begin
            state_next = ST_RUN;
            cnt_next   = '0;
            sw_next    = 1'b0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    sw_next = 1'b0;
                    if (req_reg != mode_reg) begin
                        state_next = ST_WAIT_SYM;
                        cnt_next   = '0;
                    end
                end
                ST_WAIT_SYM: begin
                    if (req_reg == mode_reg) begin
                        state_next = ST_RUN;
                        cnt_next   = '0;
                    end else if (sym_tick || cnt_reg == CNT_W'(SYM_TIMEOUT - 1)) begin
                        state_next = ST_FLUSH;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                ST_FLUSH: begin
                    if (cnt_reg == CNT_W'(FLUSH_CYC - 1)) begin
                        state_next = ST_SETTLE;
                        cnt_next   = '0;
                        mode_next  = req_reg;
                        sw_next    = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    if (cnt_reg == CNT_W'(SETTLE_CYC - 1)) begin
                        state_next = ST_RUN;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so the registered values track the state
    always_comb begin
        mute_next      = !ena || state_next == ST_FLUSH || state_next == ST_SETTLE;
        demod_en_next  = !mute_next;
        busy_next      = state_next != ST_RUN;
        dp_clr_next    = ena && state_reg == ST_FLUSH && state_next == ST_SETTLE;
        mode_done_next = ena && sw_reg && state_reg == ST_SETTLE && state_next == ST_RUN;
    end

    assign mode      = mode_reg;
    assign dp_clr    = dp_clr_reg;
    assign mute      = mute_reg;
    assign demod_en  = demod_en_reg;
    assign busy      = busy_reg;
    assign mode_done = mode_done_reg;

endmodule
